l1_request_scheduler: RTL and testbench
=======================================

// Module: l1_request_scheduler
// PURPOSE
// - Shares one L1 memory port among NUM_REQ requesters (dcache, dmmu, icache, immu, in L1 ID order).
// - Round-robin arbitration with a registered issue stage.
// - In-order tracking of outstanding reads, so that returned read data is routed back to the requester that issued it.
// - Sits between the L1 clients and the bus/memory interface.
// PARAMETERS
// - NUM_REQ          4   number of requesters; index = L1 ID
// - MAX_OUTSTANDING  4   max reads in flight; power of 2, >= 2
// PORTS
// clk           in   1            clock; all state updates on rising edge
// rst           in   1            synchronous, active-high reset
// req_valid     in   NUM_REQ      requester i has a request
// req_we        in   NUM_REQ      1 = write, 0 = read
// req_addr      in   NUM_REQ*32   packed addresses, [32*i +: 32] = requester i
// req_be        in   NUM_REQ*4    packed byte enables
// req_wdata     in   NUM_REQ*32   packed write data
// req_ready     out  NUM_REQ      one-hot grant; request i accepted this cycle
// mem_valid     out  1            issue-stage request valid
// mem_we        out  1            issued request is a write
// mem_addr      out  32           issued address
// mem_be        out  4            issued byte enables
// mem_wdata     out  32           issued write data
// mem_ready     in   1            memory accepts the issued request this cycle
// mem_rd_valid  in   1            read data return; in order of issue
// mem_rd_data   in   32           returned read data
// rd_valid      out  NUM_REQ      one-hot; read data for requester i
// rd_data       out  32           mem_rd_data passthrough
// proto_err     out  1            sticky; set on mem_rd_valid with no read pending
// BEHAVIOUR
// - Reset values: mem_valid=0; proto_err=0; rr_ptr=0; pending count=0; FIFO empty; state IDLE.
//   - mem_we, mem_addr, mem_be, mem_wdata = 0 after reset.
// - Eligibility: requester i is eligible when req_valid[i] && (req_we[i] || reads_pending < MAX_OUTSTANDING).
// - Grant selection:
//   - Search order is rr_ptr, rr_ptr+1, ... (mod NUM_REQ); the first eligible requester is granted.
//   - After a grant to i, rr_ptr <= (i+1) mod NUM_REQ.
//   - req_ready is combinational and is asserted only when `slot_free` holds.
//   - slot_free = (state==IDLE) || (state==ISSUE && mem_ready).
// - States:
//   - IDLE: if any requester is eligible, grant it and latch its fields into the issue registers -> ISSUE.
//     Otherwise stay in IDLE.
//   - ISSUE: mem_valid=1, and the issue registers hold stable until mem_ready.
//     - On mem_ready with an eligible requester: grant and latch in the same cycle; stay in ISSUE (back-to-back, 1 req/cycle).
//     - On mem_ready with no eligible requester -> IDLE (mem_valid=0 next cycle).
// - Latency: req_valid&&req_ready at cycle N -> mem_valid at cycle N+1.
// - Read tracking: at grant of a read, push the requester index into the ID FIFO and increment reads_pending.
//   - Pushing at grant (not at mem_ready) means a latched read always holds a slot.
//   - Writes are not tracked.
// - Return path:
//   - mem_rd_valid pops the FIFO head h.
//   - rd_valid = onehot(h) in the same cycle (combinational); rd_data = mem_rd_data.
// - Simultaneous read grant and mem_rd_valid: push and pop together; reads_pending unchanged.
//   - The FIFO never overflows, since the eligibility check uses the pre-pop count.
// - Empty return: mem_rd_valid with reads_pending==0 -> rd_valid=0 and proto_err<=1 (sticky until rst).
// - FIFO pointers wrap modulo MAX_OUTSTANDING; full = (reads_pending == MAX_OUTSTANDING).
// - Reset mid-operation: the in-flight request and all FIFO entries are discarded; mem_valid=0 the cycle after rst.
// - Requesters must hold req_* stable until req_ready. The scheduler may leave a request waiting indefinitely only while it is ineligible.
// TESTING
// 1. Reset, then req_valid=4'b1111, all reads, mem_ready=1:
//    -> grants in order 0,1,2,3,0; mem_valid continuous from cycle 1; after 4 grants, requester 0 is blocked until a return (FIFO full).
// 2. Only req 2 valid (write addr 0x6000_0010, be=4'hF, wdata=0xDEAD_BEEF), mem_ready low for 3 cycles:
//    -> mem_* held stable 3 cycles; no FIFO push; req 2 ready only once.
// 3. Reads from 1 then 3; return 0x11 then 0x33:
//    -> rd_valid=4'b0010 with rd_data=0x11, then rd_valid=4'b1000 with rd_data=0x33.
// 4. FIFO full (4 pending), and the cycle mem_rd_valid arrives, req 0 read and req 1 write valid:
//    -> write granted if rr_ptr favours it or the read is ineligible; reads_pending stays 4 on a simultaneous push/pop.
// 5. mem_rd_valid with nothing pending:
//    -> rd_valid=0, proto_err=1, and it stays 1 until rst.
// 6. Assert rst while in ISSUE with 2 reads pending:
//    -> next cycle mem_valid=0, rr_ptr=0; a following return raises proto_err.

Source files
------------

// File: rtl/l1_request_scheduler.sv
// l1_request_scheduler: shares one L1 memory port among NUM_REQ requesters.
// Round-robin grant into a registered issue stage. The requester ID of every
// granted read is queued so that in-order read returns can be steered back.
module l1_request_scheduler #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_we,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*4-1:0]   req_be,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   mem_valid,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  output logic [3:0]             mem_be,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_ready,
  input  logic                   mem_rd_valid,
  input  logic [31:0]            mem_rd_data,
  output logic [NUM_REQ-1:0]     rd_valid,
  output logic [31:0]            rd_data,
  output logic                   proto_err
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   id_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  reads_pending;

  logic [NUM_REQ-1:0] eligible;
  logic               any_eligible;
  logic [ID_W-1:0]    grant_idx;
  logic               slot_free;
  logic               grant;
  logic               push;
  logic               pop;
  logic               fifo_full;

  // Requester index 'offset' positions after 'base', wrapping at NUM_REQ.
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int offset);
    return ID_W'((int'(base) + offset) % NUM_REQ);
  endfunction

  // Full is judged on the count before any same-cycle pop, so a read can
  // never be granted into a slot that is only being freed this cycle.
  assign fifo_full = (reads_pending == CNT_W'(MAX_OUTSTANDING));

  // Writes are always eligible; reads need a free tracking slot.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (req_we[i] || !fifo_full);
    end
  end

  // Round-robin search starting at rr_ptr; first eligible requester wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves a value unassigned and infers a latch.
    any_eligible = 1'b0;
    grant_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_eligible && eligible[rr_index(rr_ptr, k)]) begin
        any_eligible = 1'b1;
        grant_idx    = rr_index(rr_ptr, k);
      end
    end
  end

  // The issue register can take a new request when empty or being drained.
  assign slot_free = (state == IDLE) || ((state == ISSUE) && mem_ready);
  assign grant     = slot_free && any_eligible;
  assign req_ready = grant ? (NUM_REQ'(1) << grant_idx) : '0;
  assign push      = grant && !req_we[grant_idx];
  assign pop       = mem_rd_valid && (reads_pending != '0);
  assign mem_valid = (state == ISSUE);

  // Next-state: load on grant, fall back to IDLE once drained with nothing new.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = ISSUE;
      ISSUE:   if (mem_ready && !grant) state_next = IDLE;
    endcase
  end

  // State register and round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
    end else begin
      state <= state_next;
      if (grant) rr_ptr <= rr_index(grant_idx, 1);
    end
  end

  // Issue registers: latched on grant, held stable until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else if (grant) begin
      mem_we    <= req_we[grant_idx];
      mem_addr  <= req_addr[32*grant_idx +: 32];
      mem_be    <= req_be[4*grant_idx +: 4];
      mem_wdata <= req_wdata[32*grant_idx +: 32];
    end
  end

  // ID FIFO storage: written at read grant, read at the head on return.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; validity comes from
    // reads_pending and the pointers, which are reset, so stale entries are
    // never observed and the array can map to plain registers or RAM.
    if (push) id_fifo[wr_ptr] <= grant_idx;
  end

  // FIFO pointers and outstanding-read count; push and pop together cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      reads_pending <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   reads_pending <= reads_pending + CNT_W'(1);
        2'b01:   reads_pending <= reads_pending - CNT_W'(1);
        default: reads_pending <= reads_pending;
      endcase
    end
  end

  // Sticky flag for a read return that has no matching outstanding read.
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if (mem_rd_valid && (reads_pending == '0)) begin
      proto_err <= 1'b1;
    end
  end

  assign rd_valid = pop ? (NUM_REQ'(1) << id_fifo[rd_ptr]) : '0;
  assign rd_data  = mem_rd_data;

endmodule

// File: tb/tb_l1_request_scheduler.sv
// Self-checking bench for l1_request_scheduler: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_l1_request_scheduler;

  localparam int N = 4;
  localparam int M = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_we;
  logic [N*32-1:0] req_addr;
  logic [N*4-1:0]  req_be;
  logic [N*32-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic            mem_valid;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [3:0]      mem_be;
  logic [31:0]     mem_wdata;
  logic            mem_ready;
  logic            mem_rd_valid;
  logic [31:0]     mem_rd_data;
  logic [N-1:0]    rd_valid;
  logic [31:0]     rd_data;
  logic            proto_err;
  logic [69:0]     d_mem;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign d_mem = {mem_valid, mem_we, mem_addr, mem_be, mem_wdata};

  l1_request_scheduler #(.NUM_REQ(N), .MAX_OUTSTANDING(M)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_be(req_be), .req_wdata(req_wdata), .req_ready(req_ready),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .proto_err(proto_err)
  );

  // Reference model: the issue slot as a transaction record, outstanding
  // reads as a queue of requester IDs, arbitration as a rotating search.
  int          m_rr;
  int          m_q[$];
  logic        m_iv, m_iwe, m_perr;
  logic [31:0] m_iaddr, m_iwdata;
  logic [3:0]  m_ibe;
  int          e_grant;
  logic [N-1:0] e_ready, e_rd_valid;

  function automatic logic [69:0] e_mem();
    return {m_iv, m_iwe, m_iaddr, m_ibe, m_iwdata};
  endfunction

  task automatic model_eval();
    e_grant = -1;
    if (!m_iv || mem_ready) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (e_grant < 0 && req_valid[i] && (req_we[i] || m_q.size() < M)) e_grant = i;
      end
    end
    e_ready    = (e_grant >= 0) ? N'(1 << e_grant) : '0;
    e_rd_valid = (mem_rd_valid && m_q.size() > 0) ? N'(1 << m_q[0]) : '0;
  endtask

  task automatic model_update();
    if (rst) begin
      m_rr = 0; m_q.delete(); m_iv = 0; m_iwe = 0;
      m_iaddr = '0; m_ibe = '0; m_iwdata = '0; m_perr = 0;
    end else begin
      if (mem_rd_valid) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_perr = 1;
      end
      if (e_grant >= 0) begin
        m_iv     = 1;
        m_iwe    = req_we[e_grant];
        m_iaddr  = req_addr[32*e_grant +: 32];
        m_ibe    = req_be[4*e_grant +: 4];
        m_iwdata = req_wdata[32*e_grant +: 32];
        m_rr     = (e_grant + 1) % N;
        if (!req_we[e_grant]) m_q.push_back(e_grant);
      end else if (m_iv && mem_ready) begin
        m_iv = 0;
      end
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic do_reset();
    rst = 1; req_valid = '0; req_we = '0; req_addr = '0; req_be = '0;
    req_wdata = '0; mem_ready = 0; mem_rd_valid = 0; mem_rd_data = '0;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    checks++;
    if (d_mem !== 70'd0) begin failures++; $display("FAIL reset_mem: got %h expected 0", d_mem); end
    checks++;
    if (proto_err !== 1'b0) begin failures++; $display("FAIL reset_proto_err: got %b expected 0", proto_err); end
    checks++;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++;
    if (rd_valid !== 4'b0000) begin failures++; $display("FAIL reset_rd_valid: got %b expected 0000", rd_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    do_reset();
    mem_ready = 1; req_we = '0; req_valid = 4'b1111;
    for (int i = 0; i < N; i++) req_addr[32*i +: 32] = 32'h1000_0000 | (32'(i) << 4);
    for (int c = 0; c < 6; c++) begin
      settle();
      checks++;
      if (req_ready !== exp_seq[c]) begin failures++; $display("FAIL rr_grant c%0d: got %b expected %b", c, req_ready, exp_seq[c]); end
      checks++;
      if (mem_valid !== (c >= 1 && c <= 4)) begin failures++; $display("FAIL rr_mem_valid c%0d: got %b", c, mem_valid); end
      if (c >= 1 && c <= 4) begin
        checks++;
        if (mem_addr !== (32'h1000_0000 | (32'(c - 1) << 4))) begin failures++; $display("FAIL rr_mem_addr c%0d: got %h", c, mem_addr); end
      end
      tick();
    end
    mem_rd_valid = 1; mem_rd_data = 32'h0000_00A0;
    settle();
    checks++;
    if (rd_valid !== 4'b0001) begin failures++; $display("FAIL rr_return rd_valid: got %b expected 0001", rd_valid); end
    checks++;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL rr_full_blocked: got %b expected 0000", req_ready); end
    tick();
    mem_rd_valid = 0;
    settle();
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL rr_after_return: got %b expected 0001", req_ready); end
    tick();
  endtask

  task automatic test_write_stall();
    logic [69:0] exp_mem;
    exp_mem = {1'b1, 1'b1, 32'h6000_0010, 4'hF, 32'hDEAD_BEEF};
    do_reset();
    req_valid = 4'b0100; req_we = 4'b0100;
    req_addr[64 +: 32] = 32'h6000_0010; req_be[8 +: 4] = 4'hF; req_wdata[64 +: 32] = 32'hDEAD_BEEF;
    settle();
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL ws_grant: got %b expected 0100", req_ready); end
    tick();
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++;
      if (d_mem !== exp_mem) begin failures++; $display("FAIL ws_hold c%0d: got %h expected %h", c, d_mem, exp_mem); end
      checks++;
      if (req_ready !== 4'b0000) begin failures++; $display("FAIL ws_no_regrant c%0d: got %b expected 0000", c, req_ready); end
      tick();
    end
    req_valid = '0; mem_ready = 1;
    tick();
    mem_ready = 0; mem_rd_valid = 1;
    settle();
    checks++;
    if (mem_valid !== 1'b0) begin failures++; $display("FAIL ws_drained: got %b expected 0", mem_valid); end
    checks++;
    if (rd_valid !== 4'b0000) begin failures++; $display("FAIL ws_untracked rd_valid: got %b expected 0000", rd_valid); end
    tick();
    mem_rd_valid = 0;
    settle();
    checks++;
    if (proto_err !== 1'b1) begin failures++; $display("FAIL ws_untracked proto_err: got %b expected 1", proto_err); end
  endtask

  task automatic test_read_return();
    do_reset();
    mem_ready = 1; req_we = '0;
    req_valid = 4'b0010;
    settle();
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL rt_grant1: got %b expected 0010", req_ready); end
    tick();
    req_valid = 4'b1000;
    settle();
    checks++;
    if (req_ready !== 4'b1000) begin failures++; $display("FAIL rt_grant3: got %b expected 1000", req_ready); end
    tick();
    req_valid = '0; mem_rd_valid = 1; mem_rd_data = 32'h11;
    settle();
    checks++;
    if (rd_valid !== 4'b0010 || rd_data !== 32'h11) begin failures++; $display("FAIL rt_first: got %b/%h expected 0010/11", rd_valid, rd_data); end
    tick();
    mem_rd_data = 32'h33;
    settle();
    checks++;
    if (rd_valid !== 4'b1000 || rd_data !== 32'h33) begin failures++; $display("FAIL rt_second: got %b/%h expected 1000/33", rd_valid, rd_data); end
    tick();
    mem_rd_valid = 0;
    settle();
    checks++;
    if (proto_err !== 1'b0) begin failures++; $display("FAIL rt_proto_err: got %b expected 0", proto_err); end
  endtask

  task automatic test_full_simul();
    do_reset();
    mem_ready = 1; req_we = '0; req_valid = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++;
      if (req_ready !== 4'b0001) begin failures++; $display("FAIL fs_fill c%0d: got %b expected 0001", c, req_ready); end
      tick();
    end
    settle();
    checks++;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL fs_full: got %b expected 0000", req_ready); end
    req_valid = 4'b0011; req_we = 4'b0010; mem_rd_valid = 1;
    settle();
    checks++;
    if (req_ready !== 4'b0010 || rd_valid !== 4'b0001) begin failures++; $display("FAIL fs_write_on_return: got %b/%b expected 0010/0001", req_ready, rd_valid); end
    tick();
    req_valid = 4'b0001; req_we = '0;
    settle();
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL fs_push_pop: got %b expected 0001", req_ready); end
    tick();
    mem_rd_valid = 0;
    settle();
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL fs_count_held: got %b expected 0001", req_ready); end
    tick();
    settle();
    checks++;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL fs_refull: got %b expected 0000", req_ready); end
  endtask

  task automatic test_empty_return();
    do_reset();
    mem_rd_valid = 1; mem_rd_data = 32'h5A5A_5A5A;
    settle();
    checks++;
    if (rd_valid !== 4'b0000) begin failures++; $display("FAIL er_rd_valid: got %b expected 0000", rd_valid); end
    tick();
    mem_rd_valid = 0;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++;
      if (proto_err !== 1'b1) begin failures++; $display("FAIL er_sticky c%0d: got %b expected 1", c, proto_err); end
      tick();
    end
    do_reset();
    settle();
    checks++;
    if (proto_err !== 1'b0) begin failures++; $display("FAIL er_cleared: got %b expected 0", proto_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_ready = 1; req_we = '0; req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = '0; mem_ready = 0;
    tick();
    settle();
    checks++;
    if (mem_valid !== 1'b1) begin failures++; $display("FAIL rm_in_issue: got %b expected 1", mem_valid); end
    rst = 1;
    tick();
    rst = 0;
    req_valid = 4'b1111;
    settle();
    checks++;
    if (mem_valid !== 1'b0) begin failures++; $display("FAIL rm_mem_valid: got %b expected 0", mem_valid); end
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL rm_rr_ptr: got %b expected 0001", req_ready); end
    req_valid = '0; mem_rd_valid = 1;
    settle();
    checks++;
    if (rd_valid !== 4'b0000) begin failures++; $display("FAIL rm_discarded: got %b expected 0000", rd_valid); end
    tick();
    mem_rd_valid = 0;
    settle();
    checks++;
    if (proto_err !== 1'b1) begin failures++; $display("FAIL rm_proto_err: got %b expected 1", proto_err); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i]            = 1'b1;
          req_we[i]               = 1'($urandom_range(0, 1));
          req_addr[32*i +: 32]    = $urandom();
          req_be[4*i +: 4]        = 4'($urandom());
          req_wdata[32*i +: 32]   = $urandom();
        end
      end
      mem_ready    = ($urandom_range(0, 3) != 0);
      mem_rd_valid = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
      mem_rd_data  = $urandom();
      settle();
      checks++;
      if (req_ready !== e_ready) begin failures++; $display("FAIL rnd_req_ready c%0d: got %b expected %b", c, req_ready, e_ready); end
      checks++;
      if (rd_valid !== e_rd_valid) begin failures++; $display("FAIL rnd_rd_valid c%0d: got %b expected %b", c, rd_valid, e_rd_valid); end
      checks++;
      if (rd_data !== mem_rd_data) begin failures++; $display("FAIL rnd_rd_data c%0d: got %h expected %h", c, rd_data, mem_rd_data); end
      checks++;
      if (d_mem !== e_mem()) begin failures++; $display("FAIL rnd_mem c%0d: got %h expected %h", c, d_mem, e_mem()); end
      checks++;
      if (proto_err !== m_perr) begin failures++; $display("FAIL rnd_proto_err c%0d: got %b expected %b", c, proto_err, m_perr); end
      tick();
      for (int i = 0; i < N; i++) if (e_ready[i]) req_valid[i] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_write_stall();
    test_read_return();
    test_full_simul();
    test_empty_return();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
